// File: rtl/isqrt_seq.sv
// Sequential integer square root, digit-by-digit: one root bit per clock.
// Returns floor(sqrt(num)) and num - root^2 for a 2n-bit unsigned operand.
module isqrt_seq #(
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*n-1:0] num,
  output logic           busy,
  output logic           done,
  output logic [n-1:0]   root,
  output logic [n:0]     rem
);

  localparam int unsigned NW = 2 * n;
  localparam int unsigned RW = n + 2;
  localparam int unsigned CW = $clog2(n);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_d;
  logic          busy_d;
  logic          done_d;
  logic          load_c;
  logic          step_c;
  logic          last_c;

  logic [NW-1:0] opnd;
  logic [RW-1:0] wrem;
  logic [n-1:0]  wroot;
  logic [CW-1:0] cnt;

  logic [RW-1:0] rsh_c;
  logic [RW-1:0] trial_c;
  logic [RW-1:0] rnext_c;
  logic [n-1:0]  qnext_c;
  logic          ge_c;

  // State register plus registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  assign last_c = (cnt == '0);

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_c) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode; flags are registered from the next state
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    load_c = 1'b0;
    step_c = 1'b0;
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
    load_c = start && ((state == IDLE) || (state == DONE));
    step_c = (state == CALC);
  end

  // One digit step: bring down two operand bits and try subtracting 4q+1
  always_comb begin
    rsh_c   = RW'({wrem, opnd[NW-1 -: 2]});
    trial_c = {wroot, 2'b01};
    ge_c    = (rsh_c >= trial_c);
    rnext_c = ge_c ? (rsh_c - trial_c) : rsh_c;
    qnext_c = {wroot[n-2:0], ge_c};
  end

  // Working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd  <= '0;
      wrem  <= '0;
      wroot <= '0;
      cnt   <= '0;
    end else if (load_c) begin
      opnd  <= num;
      wrem  <= '0;
      wroot <= '0;
      cnt   <= CW'(n - 1);
    end else if (step_c) begin
      opnd  <= opnd << 2;
      wrem  <= rnext_c;
      wroot <= qnext_c;
      cnt   <= cnt - CW'(1);
    end
  end

  // Result registers change only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root <= '0;
      rem  <= '0;
    end else if (step_c && last_c) begin
      root <= qnext_c;
      rem  <= rnext_c[n:0];
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed self-checking bench for isqrt_seq, with n=4 and n=8 instances.
module tb_isqrt_seq;

  logic        clk;
  logic        rst_n;

  logic        start4;
  logic [7:0]  num4;
  logic        busy4;
  logic        done4;
  logic [3:0]  root4;
  logic [4:0]  rem4;

  logic        start8;
  logic [15:0] num8;
  logic        busy8;
  logic        done8;
  logic [7:0]  root8;
  logic [8:0]  rem8;

  int errors;
  int checks;

  isqrt_seq #(.n(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .num(num4),
    .busy(busy4), .done(done4), .root(root4), .rem(rem4)
  );

  isqrt_seq #(.n(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .num(num8),
    .busy(busy8), .done(done8), .root(root8), .rem(rem8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one accepting edge, then count edges until done (bounded)
  task automatic do_op4(input logic [7:0] v, output int lat, output int busy_cycles);
    @(negedge clk);
    num4   = v;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy4) busy_cycles++;
      @(posedge clk); #1;
      if (done4) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op8(input logic [15:0] v, output int lat);
    @(negedge clk);
    num8   = v;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start4 = 1'b0; num4 = '0;
    start8 = 1'b0; num8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, root4, rem4} !== 11'd0) begin
      errors++;
      $display("FAIL reset_n4: busy=%0b done=%0b root=%0d rem=%0d, required all 0", busy4, done4, root4, rem4);
    end
    checks++;
    if ({busy8, done8, root8, rem8} !== 19'd0) begin
      errors++;
      $display("FAIL reset_n8: busy=%0b done=%0b root=%0d rem=%0d, required all 0", busy8, done8, root8, rem8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat, bc;
    do_op4(8'd0, lat, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges, required 4", lat);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d, required 4", bc);
    end
    checks++;
    if (root4 !== 4'd0 || rem4 !== 5'd0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: root=%0d rem=%0d busy=%0b, required 0 0 0", root4, rem4, busy4);
    end
    @(posedge clk); #1;
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: done=%0b busy=%0b after DONE, required 0 0", done4, busy4);
    end
  endtask

  task automatic test_values();
    logic [7:0] vin [7];
    logic [3:0] vroot [7];
    logic [4:0] vrem [7];
    int lat, bc;
    vin = '{8'd144, 8'd143, 8'd255, 8'd1, 8'd2, 8'd3, 8'd99};
    vroot = '{4'd12, 4'd11, 4'd15, 4'd1, 4'd1, 4'd1, 4'd9};
    vrem = '{5'd0, 5'd22, 5'd30, 5'd0, 5'd1, 5'd2, 5'd18};
    for (int i = 0; i < 7; i++) begin
      do_op4(vin[i], lat, bc);
      checks++;
      if (lat !== 4 || root4 !== vroot[i] || rem4 !== vrem[i]) begin
        errors++;
        $display("FAIL value_%0d: lat=%0d root=%0d rem=%0d, required lat=4 root=%0d rem=%0d",
                 vin[i], lat, root4, rem4, vroot[i], vrem[i]);
      end
    end
  endtask

  // start held high: every result accepted back-to-back, one done per 5 edges
  task automatic test_back_to_back();
    int edges;
    int exp_root;
    @(negedge clk);
    num4   = 8'd0;
    start4 = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 256; v++) begin
      edges = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        checks++;
        if (busy4 && done4) begin
          errors++;
          $display("FAIL b2b_busy_done_overlap: v=%0d", v);
        end
        if (done4) begin
          edges = k;
          break;
        end
      end
      exp_root = 0;
      while ((exp_root + 1) * (exp_root + 1) <= v) exp_root++;
      checks++;
      if (edges !== ((v == 0) ? 4 : 5)) begin
        errors++;
        $display("FAIL b2b_spacing: v=%0d got %0d edges, required %0d", v, edges, (v == 0) ? 4 : 5);
      end
      checks++;
      if (int'(root4) * int'(root4) + int'(rem4) != v || int'(rem4) > 2 * int'(root4) ||
          int'(root4) != exp_root) begin
        errors++;
        $display("FAIL b2b_result: num=%0d root=%0d rem=%0d, required root=%0d rem=%0d",
                 v, root4, rem4, exp_root, v - exp_root * exp_root);
      end
      if (v == 255) start4 = 1'b0;
      else num4 = 8'(v + 1);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_during_calc();
    int dones;
    @(negedge clk);
    num4   = 8'd200;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    num4   = 8'd9;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    num4   = 8'd50;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done4) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start_dones: got %0d done pulses, required 1", dones);
    end
    checks++;
    if (root4 !== 4'd14 || rem4 !== 5'd4) begin
      errors++;
      $display("FAIL ignore_start_result: root=%0d rem=%0d, required 14 4", root4, rem4);
    end
  endtask

  task automatic test_reset_mid_calc();
    int dones;
    @(negedge clk);
    num4   = 8'd255;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || root4 !== 4'd0 || rem4 !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%0b done=%0b root=%0d rem=%0d, required all 0",
               busy4, done4, root4, rem4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done4 || busy4) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done_after: got %0d busy/done cycles, required 0", dones);
    end
  endtask

  task automatic test_n8();
    int lat;
    do_op8(16'd65535, lat);
    checks++;
    if (lat !== 8 || root8 !== 8'd255 || rem8 !== 9'd510) begin
      errors++;
      $display("FAIL n8_65535: lat=%0d root=%0d rem=%0d, required 8 255 510", lat, root8, rem8);
    end
    do_op8(16'd65025, lat);
    checks++;
    if (lat !== 8 || root8 !== 8'd255 || rem8 !== 9'd0) begin
      errors++;
      $display("FAIL n8_65025: lat=%0d root=%0d rem=%0d, required 8 255 0", lat, root8, rem8);
    end
    do_op8(16'd1000, lat);
    checks++;
    if (lat !== 8 || root8 !== 8'd31 || rem8 !== 9'd39) begin
      errors++;
      $display("FAIL n8_1000: lat=%0d root=%0d rem=%0d, required 8 31 39", lat, root8, rem8);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_start_during_calc();
    test_reset_mid_calc();
    test_n8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Sequential integer square-root unit: the inverse of the combinational squarer. Accepts a 2n-bit unsigned operand and returns the n-bit floor square root plus remainder. Uses the bitwise digit-by-digit method, one root bit per clock. Sits beside the squarer so results can be cross-checked (root² + rem == num) in the same datapath.

## Interface
- n, default 4, root width; operand is 2n bits; legal n ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when accepting (IDLE or DONE state)
- num  input  2n  unsigned operand, sampled on the accepting edge only
- busy  output  1  high while a computation is in progress (CALC state)
- done  output  1  one-cycle pulse; root/rem valid and updated in that cycle
- root  output  n  floor(sqrt(num)); holds last result until next done
- rem  output  n+1  num − root²; holds last result until next done

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: start=1 at an edge → latch num into operand shift register, clear work remainder (n+2 bits) and work root (n bits), iteration counter = n−1, → CALC.
- CALC, per edge: r = (r << 2) | top two operand bits; operand <<= 2; trial = (q << 2) | 1; if r ≥ trial then r = r − trial, q = (q << 1) | 1, else q = q << 1. Counter decrements; after the iteration with counter = 0, copy q → root and r[n:0] → rem, → DONE.
- DONE: done=1 for exactly this cycle. start=1 → accept new operand as in IDLE, → CALC (back-to-back); else → IDLE.
- start during CALC: ignored, no effect on the running operation, not queued.
- Width rules: work remainder n+2 bits never overflows; final rem ≤ 2·root so fits n+1 bits; all arithmetic unsigned.
- num changing while busy: no effect (operand latched).

## Timing
- Reset (async assert, any time): state=IDLE, busy=0, done=0, root=0, rem=0, internal registers cleared. Reset mid-CALC aborts; no done is produced after release.
- Reset release: first start recognised at the first rising edge with rst_n high.
- Latency: start accepted at edge E0 → busy=1 after E0 → at edge E0+n state enters DONE, done=1 and root/rem updated after E0+n, busy=0 in that cycle → done=0 after E0+n+1 unless restarted.
- busy and done are never high together.
- Throughput: one result per n+1 cycles with back-to-back starts.
- root/rem change only on the edge entering DONE.

## Test plan
- Reset, then num=0, start pulse (n=4) → done exactly 4 edges after accepting edge; root=0, rem=0; busy high for 4 cycles.
- num=144 → root=12, rem=0; num=143 → root=11, rem=22; num=255 → root=15, rem=30 (max rem = 2·root).
- Exhaustive n=4, num 0..255 back-to-back starts held high → every done gives root²+rem==num, rem≤2·root, one done per 5 cycles.
- num=200, start; re-assert start with num=9 during CALC → single done with root=14, rem=4; no second result.
- num=255, start; assert rst_n=0 two cycles into CALC → busy, done, root, rem immediately 0; after release no done appears until a new start.
- n=8 parameter instance, num=65535 → root=255, rem=510 after 8 CALC edges; num=65025 → root=255, rem=0.
